ysyx_24110006_axi_sram: RTL and testbench



---
 rtl/ysyx_24110006_axi_sram.sv | 206 ++++++++++++++++++++
 tb/tb_ysyx_24110006_axi_sram.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_axi_sram.sv
// AXI4-Lite word-addressed SRAM slave, one transaction outstanding, programmable R/B latency.
// Define YSYX_24110006_RAND_DELAY_EN to draw each delay from an 8-bit LFSR instead of FIX_DELAY.
module ysyx_24110006_axi_sram #(
    parameter int          MEM_DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          FIX_DELAY      = 1
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    output logic        o_axi_arready,
    output logic [31:0] o_axi_rdata,
    output logic [1:0]  o_axi_rresp,
    output logic        o_axi_rvalid,
    input  logic        i_axi_rready,
    input  logic [31:0] i_axi_awaddr,
    input  logic        i_axi_awvalid,
    output logic        o_axi_awready,
    input  logic [31:0] i_axi_wdata,
    input  logic [7:0]  i_axi_wstrb,
    input  logic        i_axi_wvalid,
    output logic        o_axi_wready,
    output logic [1:0]  o_axi_bresp,
    output logic        o_axi_bvalid,
    input  logic        i_axi_bready
);
    localparam int          DEPTH     = 1 << MEM_DEPTH_LOG2;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_COLLECT,
        WR_WAIT,
        WR_RESP
    } state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic [31:0] araddr_q;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [3:0]  cnt;
    logic [3:0]  dly;

    logic        ar_hs;
    logic        aw_hs;
    logic        w_hs;
    logic        wr_start;
    logic        wr_pair_done;
    logic        rd_enter;
    logic        wr_enter;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        unused_strb;

    assign unused_strb = ^i_axi_wstrb[7:4];

    function automatic logic addr_ok(input logic [31:0] addr);
        logic [32:0] offset;
        offset = {1'b0, addr} - {1'b0, BASE_ADDR};
        return (addr >= BASE_ADDR) && (offset < MEM_BYTES);
    endfunction

    function automatic logic [MEM_DEPTH_LOG2-1:0] addr_idx(input logic [31:0] addr);
        return MEM_DEPTH_LOG2'((addr - BASE_ADDR) >> 2);
    endfunction

    // A zero delay skips the wait state, so the live bus values stand in for the captured ones.
    always_comb begin
        ar_hs        = (state == IDLE) && i_axi_arvalid && o_axi_arready;
        aw_hs        = i_axi_awvalid && o_axi_awready;
        w_hs         = i_axi_wvalid && o_axi_wready;
        wr_start     = (state == IDLE) && !ar_hs && (aw_hs || w_hs);
        wr_pair_done = (wr_start && aw_hs && w_hs) ||
                       ((state == WR_COLLECT) && (aw_hs || w_hs));
        rd_enter     = (ar_hs && (dly == 4'd0)) || ((state == RD_WAIT) && (cnt == 4'd1));
        wr_enter     = (wr_pair_done && (dly == 4'd0)) || ((state == WR_WAIT) && (cnt == 4'd1));
        rd_addr      = ar_hs ? i_axi_araddr : araddr_q;
        wr_addr      = aw_hs ? i_axi_awaddr : awaddr_q;
        wr_data      = w_hs ? i_axi_wdata : wdata_q;
        wr_strb      = w_hs ? i_axi_wstrb[3:0] : wstrb_q;
    end

`ifdef YSYX_24110006_RAND_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr <= 8'h05;
        end else if (ar_hs || wr_pair_done) begin
            lfsr <= {lfsr[4] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0], lfsr[7:1]};
        end
    end

    assign dly = lfsr[3:0];
`else
    assign dly = 4'(FIX_DELAY);
`endif

    always_ff @(posedge i_clock) begin
        if (wr_enter && addr_ok(wr_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[addr_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            o_axi_arready <= 1'b0;
            o_axi_awready <= 1'b0;
            o_axi_wready  <= 1'b0;
            o_axi_rvalid  <= 1'b0;
            o_axi_bvalid  <= 1'b0;
            o_axi_rdata   <= 32'h0;
            o_axi_rresp   <= 2'b00;
            o_axi_bresp   <= 2'b00;
            cnt           <= 4'd0;
            araddr_q      <= 32'h0;
            awaddr_q      <= 32'h0;
            wdata_q       <= 32'h0;
            wstrb_q       <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        araddr_q      <= i_axi_araddr;
                        o_axi_arready <= 1'b0;
                        o_axi_awready <= 1'b0;
                        o_axi_wready  <= 1'b0;
                        cnt           <= dly;
                        state         <= RD_WAIT;
                    end else if (wr_start) begin
                        if (aw_hs) awaddr_q <= i_axi_awaddr;
                        if (w_hs) begin
                            wdata_q <= i_axi_wdata;
                            wstrb_q <= i_axi_wstrb[3:0];
                        end
                        o_axi_arready <= 1'b0;
                        o_axi_awready <= !aw_hs;
                        o_axi_wready  <= !w_hs;
                        cnt           <= dly;
                        state         <= (aw_hs && w_hs) ? WR_WAIT : WR_COLLECT;
                    end else begin
                        o_axi_arready <= 1'b1;
                        o_axi_awready <= 1'b1;
                        o_axi_wready  <= 1'b1;
                    end
                end
                WR_COLLECT: begin
                    if (aw_hs || w_hs) begin
                        if (aw_hs) awaddr_q <= i_axi_awaddr;
                        if (w_hs) begin
                            wdata_q <= i_axi_wdata;
                            wstrb_q <= i_axi_wstrb[3:0];
                        end
                        o_axi_awready <= 1'b0;
                        o_axi_wready  <= 1'b0;
                        cnt           <= dly;
                        state         <= WR_WAIT;
                    end
                end
                RD_WAIT, WR_WAIT: cnt <= cnt - 4'd1;
                RD_RESP: begin
                    if (i_axi_rready) begin
                        o_axi_rvalid  <= 1'b0;
                        o_axi_arready <= 1'b1;
                        o_axi_awready <= 1'b1;
                        o_axi_wready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                WR_RESP: begin
                    if (i_axi_bready) begin
                        o_axi_bvalid  <= 1'b0;
                        o_axi_arready <= 1'b1;
                        o_axi_awready <= 1'b1;
                        o_axi_wready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Response entry overrides whatever the case chose for the next state.
            if (rd_enter) begin
                state        <= RD_RESP;
                o_axi_rvalid <= 1'b1;
                o_axi_rresp  <= addr_ok(rd_addr) ? 2'b00 : 2'b11;
                o_axi_rdata  <= addr_ok(rd_addr) ? mem[addr_idx(rd_addr)] : 32'h0;
            end
            if (wr_enter) begin
                state        <= WR_RESP;
                o_axi_bvalid <= 1'b1;
                o_axi_bresp  <= addr_ok(wr_addr) ? 2'b00 : 2'b11;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_24110006_axi_sram.sv
// Self-checking bench for ysyx_24110006_axi_sram: directed scenarios followed by randomized
// traffic, all compared against an associative-array memory model and a delay model.
module tb_ysyx_24110006_axi_sram;
    localparam int          DEPTH_LOG2 = 12;
    localparam logic [31:0] BASE       = 32'h8000_0000;
    localparam int          FIX        = 3;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_axi_araddr;
    logic        i_axi_arvalid;
    logic        o_axi_arready;
    logic [31:0] o_axi_rdata;
    logic [1:0]  o_axi_rresp;
    logic        o_axi_rvalid;
    logic        i_axi_rready;
    logic [31:0] i_axi_awaddr;
    logic        i_axi_awvalid;
    logic        o_axi_awready;
    logic [31:0] i_axi_wdata;
    logic [7:0]  i_axi_wstrb;
    logic        i_axi_wvalid;
    logic        o_axi_wready;
    logic [1:0]  o_axi_bresp;
    logic        o_axi_bvalid;
    logic        i_axi_bready;

    ysyx_24110006_axi_sram #(
        .MEM_DEPTH_LOG2(DEPTH_LOG2),
        .BASE_ADDR     (BASE),
        .FIX_DELAY     (FIX)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (i_reset_n),
        .i_axi_araddr (i_axi_araddr),
        .i_axi_arvalid(i_axi_arvalid),
        .o_axi_arready(o_axi_arready),
        .o_axi_rdata  (o_axi_rdata),
        .o_axi_rresp  (o_axi_rresp),
        .o_axi_rvalid (o_axi_rvalid),
        .i_axi_rready (i_axi_rready),
        .i_axi_awaddr (i_axi_awaddr),
        .i_axi_awvalid(i_axi_awvalid),
        .o_axi_awready(o_axi_awready),
        .i_axi_wdata  (i_axi_wdata),
        .i_axi_wstrb  (i_axi_wstrb),
        .i_axi_wvalid (i_axi_wvalid),
        .o_axi_wready (o_axi_wready),
        .o_axi_bresp  (o_axi_bresp),
        .o_axi_bvalid (o_axi_bvalid),
        .i_axi_bready (i_axi_bready)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_mem [int];
    logic [7:0]  model_lfsr;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int take_delay();
`ifdef YSYX_24110006_RAND_DELAY_EN
        int d;
        d = int'(model_lfsr[3:0]);
        model_lfsr = {model_lfsr[4] ^ model_lfsr[3] ^ model_lfsr[2] ^ model_lfsr[0], model_lfsr[7:1]};
        return d;
`else
        return FIX;
`endif
    endfunction

    function automatic bit in_range(input logic [31:0] addr);
        return (addr >= BASE) && ((addr - BASE) < (32'd4 << DEPTH_LOG2));
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int          idx;
        logic [31:0] w;
        if (in_range(addr)) begin
            idx = int'((addr - BASE) >> 2);
            w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
            for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
            model_mem[idx] = w;
        end
    endtask

    task automatic expected_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        if (in_range(addr)) begin
            data = model_mem[int'((addr - BASE) >> 2)];
            resp = 2'b00;
        end else begin
            data = 32'h0;
            resp = 2'b11;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input int bwait,
                             output logic [1:0] resp, output int lat, output int bad);
        bit aw_done, w_done, aw_hs, w_hs;
        aw_done = 0;
        w_done  = 0;
        bad     = 0;
        @(negedge clk);
        i_axi_awaddr = addr;
        i_axi_wdata  = data;
        i_axi_wstrb  = {4'h0, strb};
        for (int c = 0; c < 60 && !(aw_done && w_done); c++) begin
            i_axi_awvalid = !aw_done && ((lead > 0) ? (c >= lead) : 1'b1);
            i_axi_wvalid  = !w_done && ((lead < 0) ? (c >= -lead) : 1'b1);
            if (aw_done != w_done) begin
                if (o_axi_awready !== !aw_done || o_axi_wready !== !w_done || o_axi_arready !== 1'b0) bad++;
            end
            aw_hs = i_axi_awvalid && o_axi_awready;
            w_hs  = i_axi_wvalid && o_axi_wready;
            @(posedge clk);
            @(negedge clk);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
        end
        if (!(aw_done && w_done)) bad++;
        i_axi_awvalid = 1'b0;
        i_axi_wvalid  = 1'b0;
        lat = 0;
        while (o_axi_bvalid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        resp = o_axi_bresp;
        for (int i = 0; i < bwait; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_axi_bvalid !== 1'b1 || o_axi_bresp !== resp) bad++;
        end
        i_axi_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_axi_bready = 1'b0;
        if (o_axi_bvalid !== 1'b0 || o_axi_awready !== 1'b1 || o_axi_wready !== 1'b1 || o_axi_arready !== 1'b1) bad++;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rwait,
                            output logic [31:0] data, output logic [1:0] resp, output int lat, output int bad);
        int c;
        bad = 0;
        @(negedge clk);
        i_axi_araddr  = addr;
        i_axi_arvalid = 1'b1;
        c = 0;
        while (o_axi_arready !== 1'b1 && c < 60) begin
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        if (c >= 60) bad++;
        @(posedge clk);
        @(negedge clk);
        i_axi_arvalid = 1'b0;
        lat = 0;
        while (o_axi_rvalid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        data = o_axi_rdata;
        resp = o_axi_rresp;
        for (int i = 0; i < rwait; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_axi_rvalid !== 1'b1 || o_axi_rdata !== data || o_axi_rresp !== resp) bad++;
        end
        i_axi_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_axi_rready = 1'b0;
        if (o_axi_rvalid !== 1'b0 || o_axi_arready !== 1'b1 || o_axi_awready !== 1'b1) bad++;
    endtask

    task automatic apply_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int lead, input int bwait);
        logic [1:0] resp;
        int         lat, bad, d;
        d = take_delay();
        axi_write(addr, data, strb, lead, bwait, resp, lat, bad);
        model_write(addr, data, strb);
        check({tag, " bresp"}, 32'(resp), in_range(addr) ? 32'd0 : 32'd3);
        check({tag, " b_latency"}, lat, d);
        check({tag, " handshake"}, bad, 0);
    endtask

    task automatic apply_read(input string tag, input logic [31:0] addr, input int rwait);
        logic [31:0] data, exp_data;
        logic [1:0]  resp, exp_resp;
        int          lat, bad, d;
        d = take_delay();
        expected_read(addr, exp_data, exp_resp);
        axi_read(addr, rwait, data, resp, lat, bad);
        check({tag, " rdata"}, data, exp_data);
        check({tag, " rresp"}, 32'(resp), 32'(exp_resp));
        check({tag, " r_latency"}, lat, d);
        check({tag, " handshake"}, bad, 0);
    endtask

    initial begin
        logic [31:0] exp_data, addrs [8];
        logic [1:0]  exp_resp;
        int          d, lat, bad;

        i_reset_n     = 1'b0;
        i_axi_araddr  = 32'h0;
        i_axi_arvalid = 1'b0;
        i_axi_rready  = 1'b0;
        i_axi_awaddr  = 32'h0;
        i_axi_awvalid = 1'b0;
        i_axi_wdata   = 32'h0;
        i_axi_wstrb   = 8'h0;
        i_axi_wvalid  = 1'b0;
        i_axi_bready  = 1'b0;
        model_lfsr    = 8'h05;
        repeat (3) @(negedge clk);

        check("reset arready", 32'(o_axi_arready), 0);
        check("reset awready", 32'(o_axi_awready), 0);
        check("reset wready", 32'(o_axi_wready), 0);
        check("reset rvalid", 32'(o_axi_rvalid), 0);
        check("reset bvalid", 32'(o_axi_bvalid), 0);
        check("reset rdata", o_axi_rdata, 0);
        check("reset resps", 32'({o_axi_rresp, o_axi_bresp}), 0);
        i_reset_n = 1'b1;
        check("arready before first edge", 32'(o_axi_arready), 0);
        @(posedge clk);
        @(negedge clk);
        check("readies after first edge", 32'({o_axi_arready, o_axi_awready, o_axi_wready}), 32'h7);

        apply_write("full write", BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
        apply_read("full read", BASE + 32'h10, 0);
        apply_write("byte write", BASE + 32'h10, 32'h0000_AA00, 4'b0010, 0, 2);
        apply_read("byte read", BASE + 32'h10, 0);
        apply_write("zero strobe", BASE + 32'h10, 32'h1234_5678, 4'h0, 0, 0);
        apply_read("zero strobe read", BASE + 32'h10, 0);
        apply_write("w first", BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 3, 0);
        apply_write("aw first", BASE + 32'h24, 32'h0BAD_1DEA, 4'hF, -2, 1);
        apply_read("aw first read", BASE + 32'h24, 0);

        // Read and write presented together: read is served first.
        @(negedge clk);
        i_axi_araddr  = BASE + 32'h20;
        i_axi_awaddr  = BASE + 32'h30;
        i_axi_wdata   = 32'h5A5A_1234;
        i_axi_wstrb   = 8'h0F;
        i_axi_arvalid = 1'b1;
        i_axi_awvalid = 1'b1;
        i_axi_wvalid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_axi_arvalid = 1'b0;
        check("prio write blocked", 32'({o_axi_awready, o_axi_wready}), 0);
        d = take_delay();
        expected_read(BASE + 32'h20, exp_data, exp_resp);
        lat = 0;
        bad = 0;
        while (o_axi_rvalid !== 1'b1 && lat < 40) begin
            if (o_axi_awready !== 1'b0 || o_axi_wready !== 1'b0) bad++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("prio r_latency", lat, d);
        check("prio rdata", o_axi_rdata, exp_data);
        check("prio write held off", bad, 0);
        i_axi_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_axi_rready = 1'b0;
        check("prio readies after R", 32'({o_axi_awready, o_axi_wready}), 32'h3);
        d = take_delay();
        @(posedge clk);
        @(negedge clk);
        i_axi_awvalid = 1'b0;
        i_axi_wvalid  = 1'b0;
        lat = 0;
        while (o_axi_bvalid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("prio b_latency", lat, d);
        check("prio bresp", 32'(o_axi_bresp), 0);
        i_axi_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_axi_bready = 1'b0;
        model_write(BASE + 32'h30, 32'h5A5A_1234, 4'hF);
        apply_read("prio write read", BASE + 32'h30, 0);

        // Out-of-range accesses and an aliasing check on word 0.
        apply_write("word0 init", BASE, 32'h0F0F_0F0F, 4'hF, 0, 0);
        apply_read("below base", 32'h7FFF_FFFC, 0);
        apply_read("past end", BASE + 32'h4000, 0);
        apply_write("past end write", BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF, 0, 0);
        apply_read("word0 unchanged", BASE, 0);
        apply_read("last word", BASE + 32'h3FFC, 0);
        apply_read("rready held", BASE + 32'h20, 10);

        // Reset while the write waits for its response.
        apply_write("reset target", BASE + 32'h40, 32'h1122_3344, 4'hF, 0, 0);
        @(negedge clk);
        i_axi_awaddr  = BASE + 32'h40;
        i_axi_wdata   = 32'h5566_7788;
        i_axi_wstrb   = 8'h0F;
        i_axi_awvalid = 1'b1;
        i_axi_wvalid  = 1'b1;
        d = take_delay();
        @(posedge clk);
        @(negedge clk);
        i_axi_awvalid = 1'b0;
        i_axi_wvalid  = 1'b0;
        check("pre-reset bvalid", 32'(o_axi_bvalid), (d == 0) ? 32'd1 : 32'd0);
        if (d == 0) model_write(BASE + 32'h40, 32'h5566_7788, 4'hF);
        i_reset_n  = 1'b0;
        model_lfsr = 8'h05;
        repeat (2) @(negedge clk);
        check("in-reset outputs", 32'({o_axi_bvalid, o_axi_awready, o_axi_arready}), 0);
        i_reset_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (o_axi_bvalid !== 1'b0) bad++;
        end
        check("no bvalid after reset", bad, 0);
        apply_read("reset target read", BASE + 32'h40, 0);

        // Randomized traffic over a small pool of words.
        for (int i = 0; i < 8; i++) begin
            addrs[i] = BASE + ($urandom_range(4095, 0) << 2) + $urandom_range(3, 0);
            apply_write("rand init", addrs[i], $urandom, 4'hF, 0, 0);
        end
        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(7, 0);
            case ($urandom_range(3, 0))
                0, 1: apply_write("rand write", addrs[k], $urandom, 4'($urandom_range(15, 0)),
                                  $urandom_range(4, 0) - 2, $urandom_range(2, 0));
                2: apply_read("rand read", addrs[k], $urandom_range(3, 0));
                default: begin
                    logic [31:0] bad_addr;
                    bad_addr = $urandom_range(1, 0) ? $urandom_range(32'h7FFF_FFFF, 0)
                                                    : BASE + 32'h4000 + $urandom_range(32'h7FFF_BFFF, 0);
                    if ($urandom_range(1, 0) == 1)
                        apply_read("rand oor read", bad_addr, 0);
                    else
                        apply_write("rand oor write", bad_addr, $urandom, 4'hF, 0, 0);
                end
            endcase
        end
        for (int i = 0; i < 8; i++) apply_read("rand final read", addrs[i], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
